// File: rtl/sprite_palette_bank_pkg.sv
// Shared types and constants for the sprite palette bank: colour struct,
// power-on palette contents and the hit-flash colour.
package sprite_palette_pkg;

  // Channel width the package constants are authored in.
  localparam int RGB_CH_W = 4;

  typedef struct packed {
    logic [RGB_CH_W-1:0] r;
    logic [RGB_CH_W-1:0] g;
    logic [RGB_CH_W-1:0] b;
  } rgb_t;

  // Entry 0 is the magenta colour key.
  localparam rgb_t DEFAULT_PALETTE [16] = '{
    '{r: 4'hF, g: 4'h0, b: 4'hD},
    '{r: 4'h0, g: 4'h0, b: 4'h0},
    '{r: 4'hF, g: 4'hF, b: 4'hF},
    '{r: 4'hF, g: 4'h0, b: 4'h0},
    '{r: 4'h0, g: 4'hF, b: 4'h0},
    '{r: 4'h0, g: 4'h0, b: 4'hF},
    '{r: 4'hF, g: 4'hF, b: 4'h0},
    '{r: 4'h0, g: 4'hF, b: 4'hF},
    '{r: 4'h8, g: 4'h8, b: 4'h8},
    '{r: 4'h4, g: 4'h4, b: 4'h4},
    '{r: 4'hC, g: 4'hC, b: 4'hC},
    '{r: 4'h8, g: 4'h0, b: 4'h0},
    '{r: 4'h0, g: 4'h8, b: 4'h0},
    '{r: 4'h0, g: 4'h0, b: 4'h8},
    '{r: 4'hF, g: 4'h8, b: 4'h0},
    '{r: 4'h8, g: 4'h0, b: 4'hF}
  };

  localparam rgb_t FLASH_RGB = '{r: 4'hF, g: 4'hF, b: 4'hF};

  // Default colour for an entry; larger banks repeat the 16-entry table.
  function automatic rgb_t default_entry(logic [3:0] i);
    return DEFAULT_PALETTE[i];
  endfunction

endpackage

// File: rtl/sprite_palette_bank_if.sv
// Pixel lookup, bank select, write port and flash trigger of the palette bank.
interface sprite_palette_bank_if #(
  parameter int IDX_W   = 4,
  parameter int NUM_PAL = 4,
  parameter int CH_W    = 4
);
  localparam int PAL_W = $clog2(NUM_PAL);

  logic [IDX_W-1:0]  index;
  logic [PAL_W-1:0]  pal_sel;
  logic              frame_start;
  logic              wr_en;
  logic [PAL_W-1:0]  wr_pal;
  logic [IDX_W-1:0]  wr_idx;
  logic [3*CH_W-1:0] wr_rgb;
  logic              wr_ready;
  logic              flash_trig;
  logic [CH_W-1:0]   red;
  logic [CH_W-1:0]   green;
  logic [CH_W-1:0]   blue;
  logic              transparent;
  logic [PAL_W-1:0]  active_pal;

  modport master (
    output index, pal_sel, frame_start, wr_en, wr_pal, wr_idx, wr_rgb, flash_trig,
    input  wr_ready, red, green, blue, transparent, active_pal
  );

  modport slave (
    input  index, pal_sel, frame_start, wr_en, wr_pal, wr_idx, wr_rgb, flash_trig,
    output wr_ready, red, green, blue, transparent, active_pal
  );

endinterface

// File: rtl/sprite_palette_bank_wr_buffer.sv
// One-entry write buffer: accepts a write when empty, presents it for commit
// the following cycle, then frees itself.
module palette_wr_buffer #(
  parameter int IDX_W = 4,
  parameter int PAL_W = 2,
  parameter int RGB_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [PAL_W-1:0] wr_pal,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [RGB_W-1:0] wr_rgb,
  output logic             wr_ready,
  output logic             commit_en,
  output logic [PAL_W-1:0] commit_pal,
  output logic [IDX_W-1:0] commit_idx,
  output logic [RGB_W-1:0] commit_rgb
);

  logic             full_q, full_d;
  logic [PAL_W-1:0] pal_q, pal_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RGB_W-1:0] rgb_q, rgb_d;

  // Full buffer always drains next cycle; a request is only taken when empty.
  always_comb begin
    full_d = full_q;
    pal_d  = pal_q;
    idx_d  = idx_q;
    rgb_d  = rgb_q;
    if (full_q) begin
      full_d = 1'b0;
    end else if (wr_en) begin
      full_d = 1'b1;
      pal_d  = wr_pal;
      idx_d  = wr_idx;
      rgb_d  = wr_rgb;
    end
  end

  // Buffer state; reset discards any pending write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      pal_q  <= '0;
      idx_q  <= '0;
      rgb_q  <= '0;
    end else begin
      full_q <= full_d;
      pal_q  <= pal_d;
      idx_q  <= idx_d;
      rgb_q  <= rgb_d;
    end
  end

  assign wr_ready   = ~full_q;
  assign commit_en  = full_q;
  assign commit_pal = pal_q;
  assign commit_idx = idx_q;
  assign commit_rgb = rgb_q;

endmodule

// File: rtl/sprite_palette_bank.sv
// Multi-bank sprite palette: 2-cycle registered lookup, bank switch on
// frame_start only, buffered runtime writes.
// Optional hit-flash enabled by defining SPRITE_PAL_FLASH_EN.
module sprite_palette_bank #(
  parameter int IDX_W        = 4,
  parameter int NUM_PAL      = 4,
  parameter int CH_W         = 4,
  parameter int TRANSP_IDX   = 0,
  parameter int FLASH_FRAMES = 8
) (
  input logic                 clk,
  input logic                 rst,
  sprite_palette_bank_if.slave bus
);
  import sprite_palette_pkg::*;

  localparam int PAL_W   = $clog2(NUM_PAL);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int RGB_W   = 3 * CH_W;

  typedef logic [RGB_W-1:0] word_t;

  function automatic word_t to_word(rgb_t c);
    return {CH_W'(c.r), CH_W'(c.g), CH_W'(c.b)};
  endfunction

  logic             commit_en;
  logic [PAL_W-1:0] commit_pal;
  logic [IDX_W-1:0] commit_idx;
  word_t            commit_rgb;
  logic             flash_on;

  word_t            mem_q [NUM_PAL][ENTRIES];
  word_t            mem_d [NUM_PAL][ENTRIES];
  logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
  logic [PAL_W-1:0] s1_bank_q, s1_bank_d;
  logic [PAL_W-1:0] active_pal_q, active_pal_d;
  word_t            rgb_q, rgb_d;
  logic             transp_q, transp_d;

  palette_wr_buffer #(
    .IDX_W (IDX_W),
    .PAL_W (PAL_W),
    .RGB_W (RGB_W)
  ) u_wr_buffer (
    .clk        (clk),
    .rst        (rst),
    .wr_en      (bus.wr_en),
    .wr_pal     (bus.wr_pal),
    .wr_idx     (bus.wr_idx),
    .wr_rgb     (bus.wr_rgb),
    .wr_ready   (bus.wr_ready),
    .commit_en  (commit_en),
    .commit_pal (commit_pal),
    .commit_idx (commit_idx),
    .commit_rgb (commit_rgb)
  );

  // Commit the buffered write; reads this cycle still see the old entry.
  always_comb begin
    mem_d = mem_q;
    if (commit_en) mem_d[commit_pal][commit_idx] = commit_rgb;
  end

  // Palette storage, reloaded with the default table on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned b = 0; b < NUM_PAL; b++)
        for (int unsigned e = 0; e < ENTRIES; e++)
          mem_q[b][e] <= to_word(default_entry(e[3:0]));
    end else begin
      mem_q <= mem_d;
    end
  end

  // Stage 1 captures index with the bank in force before any switch this
  // cycle; stage 2 reads storage and applies the flash override.
  always_comb begin
    s1_idx_d     = bus.index;
    s1_bank_d    = active_pal_q;
    active_pal_d = bus.frame_start ? bus.pal_sel : active_pal_q;
    transp_d     = (s1_idx_q == IDX_W'(TRANSP_IDX));
    rgb_d        = mem_q[s1_bank_q][s1_idx_q];
    if (flash_on && !transp_d) rgb_d = '1;
  end

  // Lookup pipeline and active bank registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_idx_q     <= '0;
      s1_bank_q    <= '0;
      active_pal_q <= '0;
      rgb_q        <= '0;
      transp_q     <= 1'b0;
    end else begin
      s1_idx_q     <= s1_idx_d;
      s1_bank_q    <= s1_bank_d;
      active_pal_q <= active_pal_d;
      rgb_q        <= rgb_d;
      transp_q     <= transp_d;
    end
  end

`ifdef SPRITE_PAL_FLASH_EN
  localparam int FC_W = $clog2(FLASH_FRAMES + 1);

  logic [FC_W-1:0] flash_cnt_q, flash_cnt_d;

  // Frame countdown of the hit flash; a new trigger restarts it.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (bus.flash_trig)
      flash_cnt_d = FC_W'(FLASH_FRAMES);
    else if (bus.frame_start && flash_cnt_q != '0)
      flash_cnt_d = flash_cnt_q - FC_W'(1);
  end

  // Flash counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) flash_cnt_q <= '0;
    else     flash_cnt_q <= flash_cnt_d;
  end

  assign flash_on = (flash_cnt_q != '0);
`else
  logic unused_flash;
  assign unused_flash = ^{bus.flash_trig, FLASH_FRAMES[0]};
  assign flash_on     = 1'b0;
`endif

  assign bus.red         = rgb_q[RGB_W-1 -: CH_W];
  assign bus.green       = rgb_q[2*CH_W-1 -: CH_W];
  assign bus.blue        = rgb_q[CH_W-1:0];
  assign bus.transparent = transp_q;
  assign bus.active_pal  = active_pal_q;

endmodule
